// File: rtl/dds_sched_pkg.sv
// Shared types and constants for the DDS frequency scheduler.
package dds_sched_pkg;

    localparam int unsigned DDS_BITS = 40;
    localparam int unsigned BIT_W    = $clog2(DDS_BITS);
    localparam int unsigned CNT_W    = 16;
    localparam logic [7:0]  DDS_CTRL = 8'h00;

    typedef enum logic [2:0] {
        INIT_RH,
        INIT_RL,
        MODE,
        IDLE,
        LOAD,
        SHIFT,
        FQ,
        DWELL
    } state_e;

endpackage

// File: rtl/dds_serial_tx.sv
// 40-bit LSB-first serializer: data set up one cycle, W_CLK high the next.
module dds_serial_tx
    import dds_sched_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [DDS_BITS-1:0] word,
    input  logic                go,
    input  logic                stop,
    input  logic                tick,
    output logic                ddsdata,
    output logic                ddswclk,
    output logic                last
);

    logic [DDS_BITS-1:0] sh_q, sh_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                act_q, act_d;
    logic                ph_q, ph_d;
    logic                tail_q, tail_d;
    logic                data_q, data_d;
    logic                wclk_q, wclk_d;
    logic                last_q, last_d;

    // Next-state: load on go, alternate setup/rise phases, one low tail cycle after bit 39.
    always_comb begin
        sh_d   = sh_q;
        bit_d  = bit_q;
        act_d  = act_q;
        ph_d   = ph_q;
        tail_d = tail_q;
        data_d = data_q;
        wclk_d = 1'b0;
        last_d = 1'b0;
        if (stop) begin
            act_d  = 1'b0;
            tail_d = 1'b0;
            data_d = 1'b0;
        end else if (go) begin
            sh_d   = word;
            data_d = word[0];
            bit_d  = '0;
            ph_d   = 1'b1;
            act_d  = 1'b1;
            tail_d = 1'b0;
        end else if (tail_q) begin
            data_d = 1'b0;
            act_d  = 1'b0;
            tail_d = 1'b0;
            last_d = 1'b1;
        end else if (act_q) begin
            if (ph_q) begin
                wclk_d = 1'b1;
                ph_d   = 1'b0;
                tail_d = (bit_q == BIT_W'(DDS_BITS - 1));
            end else begin
                sh_d   = sh_q >> 1;
                data_d = sh_q[1];
                bit_d  = bit_q + BIT_W'(1);
                ph_d   = 1'b1;
            end
        end else begin
            wclk_d = tick;
        end
    end

    // Serializer registers; pins clear asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            bit_q  <= '0;
            act_q  <= 1'b0;
            ph_q   <= 1'b0;
            tail_q <= 1'b0;
            data_q <= 1'b0;
            wclk_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bit_q  <= bit_d;
            act_q  <= act_d;
            ph_q   <= ph_d;
            tail_q <= tail_d;
            data_q <= data_d;
            wclk_q <= wclk_d;
            last_q <= last_d;
        end
    end

    assign ddsdata = data_q;
    assign ddswclk = wclk_q;
    assign last    = last_q;

endmodule

// File: rtl/dds_freq_scheduler.sv
// Stepped-frequency DDS sequencer: init/serial-mode entry, then table playback with dwell.
module dds_freq_scheduler
    import dds_sched_pkg::*;
#(
    parameter  int unsigned DEPTH  = 8,
    parameter  int unsigned RST_HI = 100,
    parameter  int unsigned RST_LO = 50,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_hi,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] count,
    input  logic [15:0]   dwell,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_idx,
    output logic          ddswclk,
    output logic          ddsreset,
    output logic          ddsdata,
    output logic          ddsfqud
);

    logic [31:0]      tbl_q [DEPTH];
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    count_q, count_d;
    logic [15:0]      dwell_q, dwell_d;
    logic             rst_pin_q, rst_pin_d;
    logic             fqud_q, fqud_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             go_c, stop_c, tick_c, adv_c;
    logic             tx_last;

    // Tuning-word table, written in halves; sampled only at LOAD so in-flight words are safe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_hi) tbl_q[wr_addr][31:16] <= wr_data;
            else       tbl_q[wr_addr][15:0]  <= wr_data;
        end
    end

    // Sequencing: init timing, mode entry, word playback, dwell and abort handling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        count_d   = count_q;
        dwell_d   = dwell_q;
        rst_pin_d = 1'b0;
        fqud_d    = 1'b0;
        done_d    = 1'b0;
        go_c      = 1'b0;
        stop_c    = 1'b0;
        tick_c    = 1'b0;
        adv_c     = 1'b0;
        unique case (state_q)
            INIT_RH: begin
                rst_pin_d = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RST_HI - 1)) begin
                    state_d = INIT_RL;
                    cnt_d   = '0;
                end
            end
            INIT_RL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RST_LO - 1)) begin
                    state_d = MODE;
                    cnt_d   = '0;
                end
            end
            MODE: begin
                cnt_d  = cnt_q + CNT_W'(1);
                tick_c = (cnt_q == CNT_W'(0));
                fqud_d = (cnt_q == CNT_W'(2));
                if (cnt_q == CNT_W'(3)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (start && !abort) begin
                    count_d = count;
                    dwell_d = dwell;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    go_c    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    stop_c  = 1'b1;
                    state_d = IDLE;
                end else if (tx_last) begin
                    fqud_d  = 1'b1;
                    state_d = FQ;
                end
            end
            FQ: begin
                if (dwell_q == 16'd0) begin
                    adv_c = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(dwell_q);
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    adv_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = INIT_RH;
        endcase
        if (adv_c) begin
            if (idx_q == count_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = LOAD;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INIT_RH;
            cnt_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            dwell_q   <= '0;
            rst_pin_q <= 1'b0;
            fqud_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            dwell_q   <= dwell_d;
            rst_pin_q <= rst_pin_d;
            fqud_q    <= fqud_d;
            done_q    <= done_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    dds_serial_tx u_tx (
        .clk     (clk),
        .reset   (reset),
        .word    ({DDS_CTRL, tbl_q[idx_q]}),
        .go      (go_c),
        .stop    (stop_c),
        .tick    (tick_c),
        .ddsdata (ddsdata),
        .ddswclk (ddswclk),
        .last    (tx_last)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign cur_idx  = idx_q;
    assign ddsreset = rst_pin_q;
    assign ddsfqud  = fqud_q;

endmodule

// File: tb/tb_dds_freq_scheduler.sv
// Scoreboard bench: expected words queued at start, checked as each FQ_UD completes.
module tb_dds_freq_scheduler;
    import dds_sched_pkg::*;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned AW       = 3;
    localparam int unsigned RST_HI   = 100;
    localparam int unsigned RST_LO   = 50;
    localparam int unsigned WORD_CYC = 83;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0, wr_hi = 1'b0, start = 1'b0, abort = 1'b0;
    logic [AW-1:0] wr_addr = '0, count = '0;
    logic [15:0]   wr_data = '0, dwell = '0;
    logic          busy, done, ddswclk, ddsreset, ddsdata, ddsfqud;
    logic [AW-1:0] cur_idx;

    dds_freq_scheduler #(.DEPTH(DEPTH), .RST_HI(RST_HI), .RST_LO(RST_LO)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_hi(wr_hi),
        .wr_data(wr_data), .count(count), .dwell(dwell), .start(start), .abort(abort),
        .busy(busy), .done(done), .cur_idx(cur_idx), .ddswclk(ddswclk),
        .ddsreset(ddsreset), .ddsdata(ddsdata), .ddsfqud(ddsfqud)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] word;
        int unsigned idx;
        int unsigned cyc;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic [31:0] model_tbl [DEPTH];
    int unsigned n_checks = 0, n_errors = 0;
    int unsigned fq_cnt = 0, done_cnt = 0, overlap_cnt = 0, unexp_fq = 0;
    int unsigned exp_done_cyc = 0, last_e0 = 0;
    bit          sb_on = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: reassemble W_CLK-sampled bits, score each FQ_UD and done pulse.
    logic [39:0] rx_bits = '0;
    int unsigned rx_n = 0;
    logic        prev_wclk = 1'b0, prev_fq = 1'b0;
    always @(negedge clk) begin
        sb_entry_t e;
        if (start) begin
            rx_bits = '0;
            rx_n    = 0;
        end
        if (ddswclk && !prev_wclk) begin
            rx_bits = {ddsdata, rx_bits[39:1]};
            rx_n++;
        end
        if (ddsfqud && ddswclk) overlap_cnt++;
        if (ddsfqud && !prev_fq) begin
            fq_cnt++;
            if (sb_on) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("word", 64'(rx_bits), 64'(e.word));
                    check_eq("bit_count", 64'(rx_n), 64'(40));
                    check_eq("cur_idx", 64'(cur_idx), 64'(e.idx));
                    check_eq("fqud_cyc", 64'(cyc), 64'(e.cyc));
                end else begin
                    unexp_fq++;
                end
            end
            rx_bits = '0;
            rx_n    = 0;
        end
        if (done) begin
            done_cnt++;
            check_eq("done_cyc", 64'(cyc), 64'(exp_done_cyc));
            check_eq("busy_at_done", 64'(busy), 64'(0));
        end
        prev_wclk = ddswclk;
        prev_fq   = ddsfqud;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input int unsigned a, input logic [31:0] v);
        tick();
        wr_en = 1'b1; wr_addr = AW'(a); wr_hi = 1'b0; wr_data = v[15:0];
        tick();
        wr_hi = 1'b1; wr_data = v[31:16];
        tick();
        wr_en = 1'b0;
        model_tbl[a] = v;
    endtask

    task automatic run_seq(input int unsigned cnt, input int unsigned dw);
        sb_entry_t e;
        tick();
        start = 1'b1; count = AW'(cnt); dwell = 16'(dw);
        last_e0 = cyc + 1;
        for (int i = 0; i <= int'(cnt); i++) begin
            e.word = {8'h00, model_tbl[i]};
            e.idx  = i;
            e.cyc  = last_e0 + i * (WORD_CYC + dw) + 82;
            sb.push_back(e);
        end
        exp_done_cyc = last_e0 + (cnt + 1) * (WORD_CYC + dw);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned target);
        int n = 0;
        while (cyc < target && n < 2000) begin tick(); n++; end
        check_eq("wait_cyc_timeout", 64'(n < 2000), 64'(1));
    endtask

    task automatic finish_seq(input int unsigned done_before);
        int n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        check_eq("idle_timeout", 64'(n < 2000), 64'(1));
        @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'(0));
        check_eq("done_pulses", 64'(done_cnt - done_before), 64'(1));
    endtask

    // Reset, then measure init/mode timing; a start pulse during INIT must be ignored.
    task automatic init_check();
        int unsigned hi = 0, fall_at = 0, wclk_at = 0, wclk_hi = 0, fq_hi = 0, busy_at = 0, rel;
        sb_on = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", 64'(busy), 64'(1));
        check_eq("rst_pins", 64'({ddsreset, ddswclk, ddsdata, ddsfqud}), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_idx", 64'(cur_idx), 64'(0));
        reset = 1'b0;
        rel = cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = (i == 20);
            if (ddsreset) hi++;
            if (hi > 0 && !ddsreset && fall_at == 0) fall_at = cyc;
            if (ddswclk && wclk_at == 0) wclk_at = cyc;
            wclk_hi += 32'(ddswclk);
            fq_hi   += 32'(ddsfqud);
            if (!busy) begin
                busy_at = cyc;
                break;
            end
        end
        start = 1'b0;
        check_eq("init_hi_cycles", 64'(hi), 64'(RST_HI));
        check_eq("init_lo_cycles", 64'(wclk_at - fall_at), 64'(RST_LO));
        check_eq("mode_wclk_pulses", 64'(wclk_hi), 64'(1));
        check_eq("mode_fqud_pulses", 64'(fq_hi), 64'(1));
        check_eq("init_len_ok", 64'(busy_at >= rel + RST_HI + RST_LO + 3 &&
                                    busy_at <= rel + RST_HI + RST_LO + 5), 64'(1));
        sb_on = 1'b1;
    endtask

    initial begin
        int unsigned fq0, d0;
        init_check();
        fq0 = fq_cnt;
        repeat (30) @(negedge clk);
        check_eq("init_start_ignored", 64'(fq_cnt - fq0), 64'(0));
        check_eq("idle_after_init", 64'(busy), 64'(0));

        // Single word, dwell 0.
        wr_word(0, 32'h12345678);
        d0 = done_cnt;
        run_seq(0, 0);
        finish_seq(d0);

        // Three words, dwell 10.
        wr_word(0, 32'h11111111);
        wr_word(1, 32'h22222222);
        wr_word(2, 32'h33333333);
        d0 = done_cnt;
        run_seq(2, 10);
        finish_seq(d0);

        // Abort at bit 20 of entry 1.
        d0 = done_cnt; fq0 = fq_cnt;
        run_seq(2, 10);
        wait_cyc(last_e0 + WORD_CYC + 10 + 41);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_pins", 64'({ddswclk, ddsdata, ddsfqud}), 64'(0));
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_idx", 64'(cur_idx), 64'(1));
        sb.delete();
        exp_done_cyc = 0;
        repeat (300) @(negedge clk);
        check_eq("abort_fqud_count", 64'(fq_cnt - fq0), 64'(1));
        check_eq("abort_no_done", 64'(done_cnt - d0), 64'(0));

        // Replay from entry 0 after abort.
        d0 = done_cnt;
        run_seq(2, 0);
        finish_seq(d0);

        // Rewrite entry 1 while it shifts: old value now, new value next run.
        d0 = done_cnt;
        run_seq(2, 0);
        wait_cyc(last_e0 + WORD_CYC + 30);
        wr_word(1, 32'hCAFEBEEF);
        finish_seq(d0);
        d0 = done_cnt;
        run_seq(1, 3);
        finish_seq(d0);

        // Start together with abort in IDLE.
        fq0 = fq_cnt;
        tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort_busy", 64'(busy), 64'(0));
        repeat (120) @(negedge clk);
        check_eq("start_abort_no_word", 64'(fq_cnt - fq0), 64'(0));

        // Asynchronous reset while W_CLK is high mid-shift.
        run_seq(0, 0);
        for (int n = 0; n < 100 && !ddswclk; n++) @(negedge clk);
        check_eq("saw_wclk_high", 64'(ddswclk), 64'(1));
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_pins", 64'({ddswclk, ddsdata, ddsfqud, ddsreset}), 64'(0));
        check_eq("async_rst_busy", 64'(busy), 64'(1));
        sb.delete();
        exp_done_cyc = 0;
        init_check();

        // Playback after re-init.
        d0 = done_cnt;
        run_seq(2, 5);
        finish_seq(d0);

        check_eq("fqud_wclk_overlap", 64'(overlap_cnt), 64'(0));
        check_eq("unexpected_fqud", 64'(unexp_fq), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
